// File: rtl/dataint_crc_seq_pkg.sv
// Shared types and helpers for the CRC byte sequencer.
// Optional DATAINT_CRC_SEQ_REFLECT_EN build adds byte/result reflection.
package dataint_crc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } seq_state_t;

    function automatic logic [7:0] reflect_byte(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/dataint_crc_byte_sequencer_if.sv
// Word input and CRC result handshakes of the CRC byte sequencer.
// master = word source / result consumer, slave = sequencer.
interface dataint_crc_byte_sequencer_if #(
    parameter int CRC_WIDTH  = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BV_W  = $clog2(BYTES + 1);

    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  o_ready;
    logic                  i_last;
    logic [BV_W-1:0]       i_bytes_valid;
    logic [CRC_WIDTH-1:0]  o_crc;
    logic                  o_crc_valid;
    logic                  i_crc_ready;

    modport master (
        output i_data, i_valid, i_last, i_bytes_valid, i_crc_ready,
        input  o_ready, o_crc, o_crc_valid
    );

    modport slave (
        input  i_data, i_valid, i_last, i_bytes_valid, i_crc_ready,
        output o_ready, o_crc, o_crc_valid
    );

endinterface

// File: rtl/dataint_crc_xor_shift_cascade.sv
// One byte of bit-serial CRC update, unrolled; data enters MSB first.
module dataint_crc_xor_shift_cascade #(
    parameter int CRC_WIDTH = 32
) (
    input  logic [CRC_WIDTH-1:0] i_crc,
    input  logic [CRC_WIDTH-1:0] i_poly,
    input  logic [7:0]           i_byte,
    output logic [CRC_WIDTH-1:0] o_crc
);
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;

    always_comb begin
        c  = i_crc;
        fb = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ i_byte[i];
            c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? i_poly : '0);
        end
        o_crc = c;
    end

endmodule

// File: rtl/dataint_crc_byte_sequencer.sv
// Streaming CRC controller: feeds accepted words one byte per cycle.
// Optional DATAINT_CRC_SEQ_REFLECT_EN adds reflect_in/reflect_out.
module dataint_crc_byte_sequencer
    import dataint_crc_seq_pkg::*;
#(
    parameter int CRC_WIDTH  = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic [CRC_WIDTH-1:0] i_poly,
    input  logic [CRC_WIDTH-1:0] i_init,
    input  logic [CRC_WIDTH-1:0] i_xor_out,
`ifdef DATAINT_CRC_SEQ_REFLECT_EN
    input  logic                 i_reflect_in,
    input  logic                 i_reflect_out,
`endif
    dataint_crc_byte_sequencer_if.slave seq,
    output logic                 o_busy
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BV_W  = $clog2(BYTES + 1);
    localparam logic [BV_W-1:0] FULL = BV_W'(BYTES);

    seq_state_t            state;
    logic [DATA_WIDTH-1:0] word_reg;
    logic [BV_W-1:0]       byte_cnt;
    logic [BV_W-1:0]       limit;
    logic [BV_W-1:0]       cnt_nxt;
    logic                  last_reg;
    logic                  frame_start;
    logic [CRC_WIDTH-1:0]  poly_reg;
    logic [CRC_WIDTH-1:0]  xor_reg;
    logic [CRC_WIDTH-1:0]  crc_reg;
    logic [CRC_WIDTH-1:0]  crc_next;
    logic [CRC_WIDTH-1:0]  crc_fin;
    logic [CRC_WIDTH-1:0]  crc_q;
    logic                  crc_valid_q;
    logic [7:0]            byte_sel;
    logic [7:0]            byte_in;
    logic [BV_W-1:0]       new_limit;

    assign seq.o_ready     = (state == IDLE);
    assign seq.o_crc       = crc_q;
    assign seq.o_crc_valid = crc_valid_q;
    assign cnt_nxt         = byte_cnt + 1'b1;

    always_comb begin
        byte_sel = word_reg[{byte_cnt, 3'b000} +: 8];
    end

    // Out-of-range byte counts are clamped so the byte index stays in the word.
    always_comb begin
        new_limit = FULL;
        if (seq.i_last && seq.i_bytes_valid != '0 &&
            seq.i_bytes_valid <= FULL) begin
            new_limit = seq.i_bytes_valid;
        end
    end

`ifdef DATAINT_CRC_SEQ_REFLECT_EN
    logic refl_in_reg;
    logic refl_out_reg;
    logic [CRC_WIDTH-1:0] crc_ref;

    assign byte_in = refl_in_reg ? reflect_byte(byte_sel) : byte_sel;

    always_comb begin
        crc_ref = crc_next;
        if (refl_out_reg) begin
            for (int i = 0; i < CRC_WIDTH; i++) begin
                crc_ref[i] = crc_next[CRC_WIDTH-1-i];
            end
        end
        crc_fin = crc_ref ^ xor_reg;
    end
`else
    assign byte_in = byte_sel;

    always_comb begin
        crc_fin = crc_next ^ xor_reg;
    end
`endif

    dataint_crc_xor_shift_cascade #(
        .CRC_WIDTH(CRC_WIDTH)
    ) u_cascade (
        .i_crc (crc_reg),
        .i_poly(poly_reg),
        .i_byte(byte_in),
        .o_crc (crc_next)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            word_reg    <= '0;
            byte_cnt    <= '0;
            limit       <= FULL;
            last_reg    <= 1'b0;
            frame_start <= 1'b1;
            poly_reg    <= '0;
            xor_reg     <= '0;
            crc_reg     <= '0;
            crc_q       <= '0;
            crc_valid_q <= 1'b0;
            o_busy      <= 1'b0;
`ifdef DATAINT_CRC_SEQ_REFLECT_EN
            refl_in_reg  <= 1'b0;
            refl_out_reg <= 1'b0;
`endif
        end else if (i_clear) begin
            state       <= IDLE;
            crc_valid_q <= 1'b0;
            frame_start <= 1'b1;
            o_busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (seq.i_valid) begin
                        word_reg <= seq.i_data;
                        byte_cnt <= '0;
                        limit    <= new_limit;
                        last_reg <= seq.i_last;
                        state    <= BUSY;
                        if (frame_start) begin
                            poly_reg    <= i_poly;
                            xor_reg     <= i_xor_out;
                            crc_reg     <= i_init;
                            frame_start <= 1'b0;
                            o_busy      <= 1'b1;
`ifdef DATAINT_CRC_SEQ_REFLECT_EN
                            refl_in_reg  <= i_reflect_in;
                            refl_out_reg <= i_reflect_out;
`endif
                        end
                    end
                end
                BUSY: begin
                    crc_reg  <= crc_next;
                    byte_cnt <= cnt_nxt;
                    if (cnt_nxt == limit) begin
                        if (last_reg) begin
                            state       <= DONE;
                            crc_q       <= crc_fin;
                            crc_valid_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (seq.i_crc_ready) begin
                        crc_valid_q <= 1'b0;
                        frame_start <= 1'b1;
                        o_busy      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dataint_crc_byte_sequencer.sv
// Bench for the CRC byte sequencer: catalogue vectors, corner sequences,
// and random frames against a byte-wise CRC model.
module tb_dataint_crc_byte_sequencer;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [31:0] poly;
        logic [31:0] init;
        logic [31:0] xo;
        string       msg;
        bit          bv0;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [31:0] poly;
    logic [31:0] init;
    logic [31:0] xo;
    logic        busy;
    logic        rin;
    logic        rout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dataint_crc_byte_sequencer_if #(.CRC_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dataint_crc_byte_sequencer #(
        .CRC_WIDTH (32),
        .DATA_WIDTH(32)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clear      (clear),
        .i_poly       (poly),
        .i_init       (init),
        .i_xor_out    (xo),
`ifdef DATAINT_CRC_SEQ_REFLECT_EN
        .i_reflect_in (rin),
        .i_reflect_out(rout),
`endif
        .seq          (bus.slave),
        .o_busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Classic table-less byte-wise CRC: xor byte into the top, shift 8 times.
    function automatic logic [31:0] model(input bq_t q, input logic [31:0] p,
                                          input logic [31:0] i0, input logic [31:0] x,
                                          input bit ri, input bit ro);
        logic [31:0] c;
        logic [31:0] r;
        c = i0;
        foreach (q[k]) begin
            c = c ^ {(ri ? rev8(q[k]) : q[k]), 24'h0};
            for (int b = 0; b < 8; b++) begin
                c = c[31] ? ((c << 1) ^ p) : (c << 1);
            end
        end
        r = c;
        if (ro) for (int b = 0; b < 32; b++) r[b] = c[31-b];
        return r ^ x;
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic send_word(input logic [31:0] d, input bit last,
                             input logic [2:0] bv);
        int n;
        bus.i_data        = d;
        bus.i_last        = last;
        bus.i_bytes_valid = bv;
        bus.i_valid       = 1'b1;
        n = 0;
        while (!bus.o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: ready got 0 expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_data  = $urandom;
    endtask

    // Feeds a frame, optionally scrambling config after word 0, then collects it.
    task automatic run_frame(input bq_t q, input bit bv0, input int hold,
                             input bit mid, output logic [31:0] crc,
                             output int lat);
        int nw;
        int rem;
        logic [31:0] d;
        logic [31:0] held;
        nw  = (q.size() + 3) / 4;
        lat = 0;
        crc = 'x;
        for (int w = 0; w < nw; w++) begin
            d   = $urandom;
            rem = q.size() - 4 * w;
            if (rem > 4) rem = 4;
            for (int k = 0; k < rem; k++) d[8*k +: 8] = q[4*w + k];
            if (w == nw - 1)
                send_word(d, 1'b1, (rem == 4 && bv0) ? 3'd0 : 3'(rem));
            else
                send_word(d, 1'b0, 3'($urandom_range(0, 4)));
            if (mid && w == 0) begin
                poly = $urandom;
                init = $urandom;
                xo   = $urandom;
                rin  = ~rin;
                rout = ~rout;
            end
        end
        while (!bus.o_crc_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("crc_valid_rise", 32'(bus.o_crc_valid), 32'd1);
        held = bus.o_crc;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_crc_stable", bus.o_crc, held);
            check("hold_ready_low", 32'(bus.o_ready), 32'd0);
            check("hold_busy_high", 32'(busy), 32'd1);
        end
        crc = bus.o_crc;
        bus.i_crc_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_crc_ready = 1'b0;
        check("valid_drop", 32'(bus.o_crc_valid), 32'd0);
        check("busy_drop", 32'(busy), 32'd0);
    endtask

    vec_t        tv[4];
    logic [31:0] got;
    logic [31:0] exp;
    int          lat;
    bit          seen;
    bq_t         q;

    initial begin
        tv[0] = '{32'h04C11DB7, 32'hFFFFFFFF, 32'h00000000, "123456789", 1'b0, 32'h0376E6E7};
        tv[1] = '{32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, "123456789", 1'b0, 32'hFC891918};
        tv[2] = '{32'h04C11DB7, 32'h00000000, 32'hFFFFFFFF, "123456789", 1'b0, 32'h765E7680};
        tv[3] = '{32'h814141AB, 32'h00000000, 32'h00000000, "123456789", 1'b0, 32'h3010BF7F};

        rst = 1'b1;
        clear = 1'b0;
        poly = '0;
        init = '0;
        xo = '0;
        rin = 1'b0;
        rout = 1'b0;
        bus.i_data = '0;
        bus.i_valid = 1'b0;
        bus.i_last = 1'b0;
        bus.i_bytes_valid = '0;
        bus.i_crc_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_crc_valid", 32'(bus.o_crc_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_crc", bus.o_crc, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tv[i]) begin
            poly = tv[i].poly;
            init = tv[i].init;
            xo   = tv[i].xo;
            run_frame(str2q(tv[i].msg), tv[i].bv0, i, 1'b0, got, lat);
            check($sformatf("vec%0d_crc", i), got, tv[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
        end

        // Single byte: exactly one BUSY cycle.
        poly = 32'h04C11DB7;
        init = 32'hFFFFFFFF;
        xo   = 32'h0;
        q    = str2q("A");
        run_frame(q, 1'b0, 0, 1'b0, got, lat);
        check("one_byte_crc", got, model(q, poly, init, xo, 1'b0, 1'b0));
        check("one_byte_latency", 32'(lat), 32'd1);

        // Full last word signalled by bytes_valid=0.
        q = str2q("12345678");
        run_frame(q, 1'b1, 0, 1'b0, got, lat);
        check("bv0_crc", got, model(q, poly, init, xo, 1'b0, 1'b0));
        check("bv0_latency", 32'(lat), 32'd4);

        // Crc_ready outside DONE must not disturb a frame.
        bus.i_crc_ready = 1'b1;
        @(negedge clk);
        check("stray_ready_idle", 32'(bus.o_ready), 32'd1);
        bus.i_crc_ready = 1'b0;

        // Abort during the second word, then a clean frame.
        send_word(32'h34333231, 1'b0, 3'd0);
        send_word(32'h38373635, 1'b0, 3'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_ready", 32'(bus.o_ready), 32'd1);
        check("clear_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.o_crc_valid) seen = 1'b1;
        end
        check("clear_no_valid", 32'(seen), 32'd0);
        run_frame(str2q("123456789"), 1'b0, 0, 1'b0, got, lat);
        check("after_clear_crc", got, 32'h0376E6E7);

        // Config changes after the first word must be ignored.
        run_frame(str2q("123456789"), 1'b0, 5, 1'b1, got, lat);
        check("midcfg_crc", got, 32'h0376E6E7);
        rin  = 1'b0;
        rout = 1'b0;

`ifdef DATAINT_CRC_SEQ_REFLECT_EN
        poly = 32'h04C11DB7;
        init = 32'hFFFFFFFF;
        xo   = 32'hFFFFFFFF;
        rin  = 1'b1;
        rout = 1'b1;
        run_frame(str2q("123456789"), 1'b0, 0, 1'b0, got, lat);
        check("reflect_crc32", got, 32'hCBF43926);
`endif

        for (int f = 0; f < 30; f++) begin
            q.delete();
            for (int k = 0; k < $urandom_range(1, 12); k++) q.push_back(8'($urandom));
            poly = $urandom | 32'h1;
            init = $urandom;
            xo   = $urandom;
`ifdef DATAINT_CRC_SEQ_REFLECT_EN
            rin  = 1'($urandom);
            rout = 1'($urandom);
`else
            rin  = 1'b0;
            rout = 1'b0;
`endif
            exp = model(q, poly, init, xo, rin, rout);
            run_frame(q, 1'($urandom), $urandom_range(0, 3), 1'($urandom), got, lat);
            check($sformatf("rand%0d_crc", f), got, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: time got limit expected finish");
        $fatal(1, "timeout");
    end

endmodule
